// File: rtl/tx_block_scheduler_if.sv
// Stream bundle for tx_block_scheduler: two byte requesters in, one byte stream out.
// Latency: n/a (wires only).
// Backpressure: each source stalls on its own tready; the output stalls on m_axis_tready.
//
// Signals:
//   s0_axis_tdata/tvalid/tlast/tready : external byte source (requester 0)
//   s1_tdata/tvalid/tready            : PRBS test source (requester 1, no tlast)
//   m_axis_tdata/tvalid/tlast/tready  : scheduled byte stream to the block shaper
// slave  : the scheduler's view of the bundle.
// master : the view of the logic around the scheduler (sources and sink).
interface tx_block_scheduler_if;
  logic [7:0] s0_axis_tdata;
  logic       s0_axis_tvalid;
  logic       s0_axis_tlast;
  logic       s0_axis_tready;
  logic [7:0] s1_tdata;
  logic       s1_tvalid;
  logic       s1_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tlast;
  logic       m_axis_tready;

  modport slave (
    input  s0_axis_tdata, s0_axis_tvalid, s0_axis_tlast, s1_tdata, s1_tvalid, m_axis_tready,
    output s0_axis_tready, s1_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport master (
    output s0_axis_tdata, s0_axis_tvalid, s0_axis_tlast, s1_tdata, s1_tvalid, m_axis_tready,
    input  s0_axis_tready, s1_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/tx_block_scheduler.sv
// Round-robin scheduler that cuts two byte sources into fixed BLOCK_LEN-byte transport blocks.
// Latency: one cycle IDLE->XFER for grant/cfg load; data path is combinational source->m_axis.
// Backpressure: m_axis_tready passes straight to the granted source; everything else sees tready=0.
//
// Ports:
//   clk, rst (async active-low)
//   bus            : tx_block_scheduler_if.slave (s0, s1 and m_axis streams)
//   src_en[1:0]    : per-requester enable
//   ss_in/m_in/bw_in -> cfg_ss/cfg_m/cfg_bw : PHY config sampled once per block, cfg_upd pulses on load
//   grant[1:0]     : one-hot owner of the current block (held through the gap), 0 when idle
//   blk_cnt[15:0]  : completed blocks, wraps
//   short_err      : one-cycle pulse when s0 ends a frame before the block is full
// Build option TX_BLOCK_SCHED_PAD_EN: when defined an early s0 tlast is padded out with zero bytes
// to a full block; otherwise the early tlast is forwarded and closes a short block.
module tx_block_scheduler #(
  parameter int unsigned BLOCK_LEN = 476,
  parameter int unsigned GAP_LEN   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  tx_block_scheduler_if.slave  bus,
  input  logic [1:0]           src_en,
  input  logic [3:0]           ss_in,
  input  logic [2:0]           m_in,
  input  logic [2:0]           bw_in,
  output logic [3:0]           cfg_ss,
  output logic [2:0]           cfg_m,
  output logic [2:0]           cfg_bw,
  output logic                 cfg_upd,
  output logic [1:0]           grant,
  output logic [15:0]          blk_cnt,
  output logic                 short_err
);

  localparam int unsigned      CNT_W    = $clog2(BLOCK_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);
  localparam logic [7:0]       GAP_LAST = (GAP_LEN > 0) ? 8'(GAP_LEN - 1) : 8'd0;

  typedef enum logic [1:0] {IDLE, XFER, PAD, GAP} state_t;

  state_t           state_q, state_d, end_state;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       gap_q;
  logic [1:0]       grant_q;
  logic             rr_ptr;       // requester that wins when both ask

  logic             req0, req1, at_last, s0_early;
  logic             win, start_blk, cnt_inc, blk_done, short_hit, gap_inc;
  logic [7:0]       m_tdata;
  logic             m_tvalid, m_tlast, s0_rdy, s1_rdy;

  assign req0      = src_en[0] & bus.s0_axis_tvalid;
  assign req1      = src_en[1] & bus.s1_tvalid;
  assign at_last   = (cnt_q == LAST_IDX);
  // tlast on the final byte of a block is the normal end, not an error
  assign s0_early  = grant_q[0] & bus.s0_axis_tlast & ~at_last;
  assign end_state = (GAP_LEN == 0) ? IDLE : GAP;

  assign bus.m_axis_tdata   = m_tdata;
  assign bus.m_axis_tvalid  = m_tvalid;
  assign bus.m_axis_tlast   = m_tlast;
  assign bus.s0_axis_tready = s0_rdy;
  assign bus.s1_tready      = s1_rdy;
  assign grant              = grant_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    m_tdata   = 8'd0;
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    s0_rdy    = 1'b0;
    s1_rdy    = 1'b0;
    win       = 1'b0;
    start_blk = 1'b0;
    cnt_inc   = 1'b0;
    blk_done  = 1'b0;
    short_hit = 1'b0;
    gap_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          start_blk = 1'b1;
          win       = (req0 & req1) ? rr_ptr : req1;
          state_d   = XFER;
        end
      end
      XFER: begin
        if (grant_q[0]) begin
          m_tdata  = bus.s0_axis_tdata;
          m_tvalid = bus.s0_axis_tvalid;
          s0_rdy   = bus.m_axis_tready;
        end else begin
          m_tdata  = bus.s1_tdata;
          m_tvalid = bus.s1_tvalid;
          s1_rdy   = bus.m_axis_tready;
        end
`ifdef TX_BLOCK_SCHED_PAD_EN
        m_tlast = at_last;
`else
        m_tlast = at_last | s0_early;
`endif
        if (m_tvalid && bus.m_axis_tready) begin
          if (at_last) begin
            blk_done = 1'b1;
            state_d  = end_state;
          end else if (s0_early) begin
            short_hit = 1'b1;
`ifdef TX_BLOCK_SCHED_PAD_EN
            cnt_inc = 1'b1;
            state_d = PAD;
`else
            blk_done = 1'b1;
            state_d  = end_state;
`endif
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
`ifdef TX_BLOCK_SCHED_PAD_EN
      PAD: begin
        // zero fill; the source is held off so its next frame waits for a fresh block
        m_tvalid = 1'b1;
        m_tlast  = at_last;
        if (bus.m_axis_tready) begin
          if (at_last) begin
            blk_done = 1'b1;
            state_d  = end_state;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
`endif
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_inc = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      gap_q     <= 8'd0;
      grant_q   <= 2'b00;
      rr_ptr    <= 1'b0;
      cfg_ss    <= 4'd0;
      cfg_m     <= 3'd0;
      cfg_bw    <= 3'd0;
      cfg_upd   <= 1'b0;
      short_err <= 1'b0;
      blk_cnt   <= 16'd0;
    end else begin
      cfg_upd   <= start_blk;
      short_err <= short_hit;
      if (start_blk) begin
        grant_q <= win ? 2'b10 : 2'b01;
        rr_ptr  <= ~win;
        cfg_ss  <= ss_in;
        cfg_m   <= m_in;
        cfg_bw  <= bw_in;
        cnt_q   <= '0;
      end
      if (cnt_inc) cnt_q <= cnt_q + 1'b1;
      if (blk_done) begin
        blk_cnt <= blk_cnt + 16'd1;
        gap_q   <= 8'd0;
        if (GAP_LEN == 0) grant_q <= 2'b00;
      end
      if (gap_inc) gap_q <= gap_q + 8'd1;
      if (state_q == GAP && state_d == IDLE) grant_q <= 2'b00;
    end
  end

endmodule

// File: doc/tx_block_scheduler.md
TX_BLOCK_SCHEDULER -- requirements
Module: tx_block_scheduler

Interface
REQ-001 SHALL have parameter BLOCK_LEN, default 476, transport-block length in bytes (2..65535).
REQ-002 SHALL have parameter GAP_LEN, default 5, idle cycles between blocks (0..255).
REQ-003 SHALL have port clk, input, 1, sole clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports s0_axis_tdata/tvalid/tlast, input, 8/1/1, external byte source (requester 0).
REQ-006 SHALL have port s0_axis_tready, output, 1, requester 0 accept.
REQ-007 SHALL have ports s1_tdata/s1_tvalid, input, 8/1, PRBS test source (requester 1, no tlast).
REQ-008 SHALL have port s1_tready, output, 1, requester 1 accept.
REQ-009 SHALL have port src_en, input, 2, per-requester enable, bit i = requester i.
REQ-010 SHALL have ports ss_in/m_in/bw_in, input, 4/3/3, requested PHY configuration.
REQ-011 SHALL have ports m_axis_tdata/tvalid/tlast, output, 8/1/1, byte stream to transport block shaper.
REQ-012 SHALL have port m_axis_tready, input, 1, downstream accept.
REQ-013 SHALL have ports cfg_ss/cfg_m/cfg_bw, output, 4/3/3, configuration held for current block.
REQ-014 SHALL have port cfg_upd, output, 1, one-cycle pulse when cfg_* change.
REQ-015 SHALL have port grant, output, 2, one-hot owner of current block, 0 when none.
REQ-016 SHALL have port blk_cnt, output, 16, completed blocks, wraps 65535->0.
REQ-017 SHALL have port short_err, output, 1, one-cycle pulse on early s0 tlast.

Function
REQ-018 SHALL implement states IDLE, XFER, PAD, GAP.
REQ-019 IDLE: request_i = src_en[i] & valid_i; if any request, next cycle SHALL be XFER with grant registered, cfg_* loaded from ss_in/m_in/bw_in, cfg_upd=1 for that cycle, byte count=0.
REQ-020 Arbitration SHALL be round-robin per block: on two requests, the requester not granted last wins; after reset requester 0 wins.
REQ-021 XFER: m_axis_tdata/tvalid SHALL combinationally follow granted source; granted tready = m_axis_tready; other tready=0.
REQ-022 A byte SHALL transfer when m_axis_tvalid & m_axis_tready; count increments only then.
REQ-023 m_axis_tlast SHALL be 1 exactly on byte count BLOCK_LEN-1; after that transfer, blk_cnt+1 and go GAP (IDLE if GAP_LEN=0).
REQ-024 s0 bytes beyond BLOCK_LEN without tlast SHALL start a new arbitration; no error.
REQ-025 Deasserting src_en mid-block SHALL NOT abort the block.
REQ-026 GAP: all tready=0, m_axis_tvalid=0, grant held, GAP_LEN cycles, then IDLE.
REQ-027 cfg_* SHALL change only on cfg_upd; ss_in/m_in/bw_in changes mid-block ignored.
REQ-028 Count width SHALL be clog2(BLOCK_LEN); no wrap within a block.

Reset
REQ-029 rst=0 SHALL immediately force IDLE, count=0, blk_cnt=0, grant=0, cfg_*=0, cfg_upd=0, short_err=0, m_axis_tvalid=0, m_axis_tlast=0, all tready=0, round-robin pointer to requester 0.
REQ-030 Reset mid-block SHALL discard the partial block; no tlast emitted.

Configuration
REQ-031 Macro TX_BLOCK_SCHED_PAD_EN SHALL select early-tlast handling.
REQ-032 With it defined: s0 tlast accepted at count<BLOCK_LEN-1 SHALL pulse short_err, go PAD, emit zero bytes (tvalid=1, s0_tready=0) until count BLOCK_LEN-1 with tlast, then normal completion.
REQ-033 Without it: early s0 tlast SHALL pulse short_err, output it with m_axis_tlast=1, end block, increment blk_cnt, go GAP; PAD unreachable.

Verification (BLOCK_LEN=8, GAP_LEN=2)
REQ-034 s0 only, 8 bytes 0x01..0x08, tready=1 -> cfg_upd 1 cycle, grant=01, tlast on 0x08, blk_cnt=1, 2 gap cycles with tready=0.
REQ-035 s0 and s1 valid continuously, src_en=11 -> grants 01,10,01,10; 8 bytes each; blk_cnt=4.
REQ-036 m_axis_tready toggled 1010 during block -> no byte lost or duplicated; tlast on 8th accepted byte.
REQ-037 s0 tlast on 3rd byte: PAD_EN -> short_err, 5 zero bytes, tlast on 8th; no PAD_EN -> short_err, tlast on 3rd, blk_cnt=1.
REQ-038 m_in 2->4 at byte 3 -> cfg_m=2 to block end, cfg_m=4 with next cfg_upd.
REQ-039 rst low at byte 5 -> all outputs reset values same cycle; after release, next block starts count 0, grant=01.
